// File: rtl/adder_bench_pkg.sv
// adder_bench_pkg: shared definitions for the adder benchmarking set.
//   ST_IDLE/ST_RUN/ST_DONE : sequencer state encodings (2'd3 is illegal)
//   seq_state_e            : enum built on those encodings
package adder_bench_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_RUN     = ST_RUN,
        S_DONE    = ST_DONE,
        S_ILLEGAL = 2'd3
    } seq_state_e;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit full adder made from two half adders plus an OR.
//   a_i, b_i : addend bits
//   cin_i    : carry in
//   s_o      : sum bit
//   cout_o   : carry out
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic s0, c0, c1;

    half_adder u_ha0 (.a_i(a_i), .b_i(b_i),   .s_o(s0),  .c_o(c0));
    half_adder u_ha1 (.a_i(s0),  .b_i(cin_i), .s_o(s_o), .c_o(c1));

    // Both half-adder carries can never be 1 together, so OR suffices.
    assign cout_o = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// half_adder: single-bit half adder.
//   a_i, b_i : addend bits
//   s_o      : sum bit
//   c_o      : carry out
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial add/subtract, one bit per clock, LSB first.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_a, in_b, in_sub: 1 = A-B)
//   out_valid/out_ready : result handshake
//   out_sum             : WIDTH-bit result (modulo 2^WIDTH)
//   out_carry           : carry out of MSB (subtract: 1 = no borrow)
//   out_ovf             : signed overflow
//   busy                : high while computing or holding a result
module serial_add_sequencer
    import adder_bench_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             busy
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;      // operand A, also collects the result
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s, fa_cout;

    full_adder_cell u_fa (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .cin_i (carry_q),
        .s_o   (fa_s),
        .cout_o(fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtract as A + ~B + 1: invert B, seed carry with 1.
                    a_d     = in_a;
                    b_d     = in_b ^ {WIDTH{in_sub}};
                    carry_d = in_sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A's consumed LSB slot is reused: sum bits enter at the MSB,
                // so after WIDTH shifts a_q holds the full result.
                a_d     = {fa_s, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {fa_s, a_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;   // carry into MSB ^ carry out
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_sum   = sum_q;
    assign out_carry = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] sum, output logic carry, output logic ovf);
        int ua, ub, full, sa, sb, r;
        ua = int'(a); ub = int'(b);
        full  = sub ? (ua + (1 << W) - ub) : (ua + ub);
        sum   = W'(full);
        carry = ((full >> W) & 1) != 0;
        sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
        r  = sub ? sa - sb : sa + sb;
        ovf = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction

    // One full transaction: present operands, count edges until out_valid,
    // optionally hold the result under backpressure, then retire it.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input int hold, input int exp_lat,
                      output logic [W-1:0] s, output logic c, output logic o);
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_idle", in_ready, 1);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_sub = ~sub;   // don't-care after acceptance
        lat = 1;
        while (lat < 50) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready !== 1'b0) begin
                check("in_ready_run", in_ready, 0);
            end
            lat++;
        end
        if (exp_lat > 0) check("latency", lat, exp_lat);
        if (lat >= 50) check("timeout_out_valid", 0, 1);
        s = out_sum; c = out_carry; o = out_ovf;
        for (int i = 0; i < hold; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum", {out_sum, out_carry, out_ovf}, {s, c, o});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("ret_valid", out_valid, 0);
        check("ret_in_ready", in_ready, 1);
    endtask

    vec_t         vt[6];
    logic [W-1:0] s, es;
    logic         c, o, ec, eo;

    initial begin
        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vt[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outs", {out_sum, out_carry, out_ovf, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        foreach (vt[i]) begin
            op(vt[i].a, vt[i].b, vt[i].sub, 0, W + 1, s, c, o);
            check($sformatf("vec%0d_sum", i), s, vt[i].sum);
            check($sformatf("vec%0d_carry", i), c, vt[i].carry);
            check($sformatf("vec%0d_ovf", i), o, vt[i].ovf);
        end

        // Backpressure: hold out_ready low for 5 cycles in DONE
        op(8'h5A, 8'h3C, 1'b0, 5, W + 1, s, c, o);
        check("bp_result", {s, c, o}, {8'h96, 1'b0, 1'b1});

        // Reset mid-RUN
        @(negedge clk);
        in_a = 8'hAA; in_b = 8'h55; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_outs", {out_sum, out_carry, out_ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(8'h01, 8'h01, 1'b0, 0, W + 1, s, c, o);
        check("post_rst_result", {s, c, o}, {8'h02, 1'b0, 1'b0});

        // Random transactions vs model
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            model(ra, rb, rs, es, ec, eo);
            op(ra, rb, rs, $urandom_range(0, 2), W + 1, s, c, o);
            check($sformatf("rnd%0d_%0h_%0h_%0d", i, ra, rb, rs), {s, c, o}, {es, ec, eo});
        end

        // Back-to-back: out_ready high, in_valid held for 3 ops
        begin
            logic [W-1:0] qs[$];
            logic         qc[$], qo[$];
            int acc_cyc[$];
            int n_acc = 0, n_res = 0, cyc = 0;
            @(negedge clk);
            out_ready = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
            in_valid = 1'b1;
            while (n_res < 3 && cyc < 200) begin
                // sampled at negedge: decide what the coming edge does
                if (out_valid) begin
                    check($sformatf("b2b%0d", n_res), {out_sum, out_carry, out_ovf},
                          {qs.pop_front(), qc.pop_front(), qo.pop_front()});
                    n_res++;
                end
                if (in_valid && in_ready) begin
                    model(in_a, in_b, in_sub, es, ec, eo);
                    qs.push_back(es); qc.push_back(ec); qo.push_back(eo);
                    acc_cyc.push_back(cyc);
                    n_acc++;
                end
                @(negedge clk);
                cyc++;
                if (n_acc == 3) in_valid = 1'b0;
                else begin
                    in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
                end
            end
            if (n_res < 3) check("b2b_timeout", n_res, 3);
            check("b2b_accepts", n_acc, 3);
            if (acc_cyc.size() == 3) begin
                check("b2b_gap0", acc_cyc[1] - acc_cyc[0], W + 2);
                check("b2b_gap1", acc_cyc[2] - acc_cyc[1], W + 2);
            end
            out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
